// File: rtl/posit_defines.sv
// Shared posit-decoded stream types and width helpers.
// Width helpers are constant functions, usable in parameter and port declarations.
package posit_defines;

  typedef enum logic [1:0] {NORMAL, PRODUCT, SUM} pd_type_t;

  typedef enum logic {IDLE, LOCKED} pd_arb_state_t;

  function automatic int get_scale_width(input int pw, input int es, input pd_type_t t);
    return (t == NORMAL) ? ($clog2(pw) + es + 1) : ($clog2(pw) + es + 2);
  endfunction

  // Products carry a double-width fraction; sums keep three extra alignment bits.
  function automatic int get_fraction_width(input int pw, input int es, input pd_type_t t);
    return (t == NORMAL)  ? (pw - es - 3) :
           (t == PRODUCT) ? (2 * (pw - es - 3) + 2) : (pw - es);
  endfunction

  function automatic int get_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pd_control_if.sv
// Posit-decoded control stream: rts/rtr handshake, sow/eow framing, decoded fields.
interface pd_control_if
  import posit_defines::*;
#(
  parameter int       POSIT_WIDTH = 32,
  parameter int       POSIT_ES    = 2,
  parameter pd_type_t PD_TYPE     = NORMAL
);
  localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

  logic          rts;
  logic          rtr;
  logic          sow;
  logic          eow;
  logic [SW-1:0] scale;
  logic [FW-1:0] fraction;
  logic          nar;
  logic          sign;
  logic          zero;
  logic          guard;
  logic          round;
  logic          sticky;

  modport master (output rts, sow, eow, scale, fraction, nar, sign, zero, guard, round, sticky,
                  input  rtr);
  modport slave  (input  rts, sow, eow, scale, fraction, nar, sign, zero, guard, round, sticky,
                  output rtr);
endinterface

// File: rtl/pd_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Rotates a doubled request vector by ptr and priority-encodes the lowest bit.
module rr_pick
  import posit_defines::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = get_id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx
);
  localparam logic [ID_W:0] N_L = (ID_W+1)'(N);

  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;

  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= N_L) ? ID_W'(sum - N_L) : sum[ID_W-1:0];
    any = |req;
  end
endmodule

// File: rtl/pd_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging N_REQ pd streams into one shared stage.
// One-entry registered output buffer; owner rtr = !obuf_valid || out.rtr.
module pd_stream_arbiter
  import posit_defines::*;
#(
  parameter  int       POSIT_WIDTH = 32,
  parameter  int       POSIT_ES    = 2,
  parameter  pd_type_t PD_TYPE     = NORMAL,
  parameter  int       N_REQ       = 4,
  localparam int       ID_W        = get_id_width(N_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  pd_control_if.slave     in [N_REQ],
  pd_control_if.master    out,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid,
  output logic            proto_err,
  output logic [31:0]     pkt_cnt
);
  localparam int SW    = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int FW    = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
  localparam int BW    = SW + FW + 8;
  localparam int SOW_B = BW - 1;
  localparam int EOW_B = BW - 2;

  pd_arb_state_t   state;
  logic [ID_W-1:0] ptr;
  logic            first_beat;
  logic            obuf_valid;
  logic [BW-1:0]   obuf;

  logic [N_REQ-1:0] req_rts;
  logic [N_REQ-1:0] req_rtr;
  logic [BW-1:0]    req_beat [N_REQ];
  logic [BW-1:0]    sel_beat;
  logic             xfer_in;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;

  // Beat layout: {sow, eow, nar, sign, zero, guard, round, sticky, scale, fraction}.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign req_rts[i]  = in[i].rts;
    assign req_beat[i] = {in[i].sow, in[i].eow, in[i].nar, in[i].sign, in[i].zero,
                          in[i].guard, in[i].round, in[i].sticky, in[i].scale, in[i].fraction};
    assign in[i].rtr   = req_rtr[i];
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req_rts),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    req_rtr = '0;
    if (state == LOCKED) req_rtr[grant_id] = !obuf_valid || out.rtr;
  end

  assign sel_beat = req_beat[grant_id];
  assign xfer_in  = req_rts[grant_id] && req_rtr[grant_id];

  assign out.rts = obuf_valid;
  assign {out.sow, out.eow, out.nar, out.sign, out.zero, out.guard, out.round,
          out.sticky, out.scale, out.fraction} = obuf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      first_beat  <= 1'b0;
      obuf_valid  <= 1'b0;
      obuf        <= '0;
      proto_err   <= 1'b0;
      pkt_cnt     <= '0;
    end else begin
      // A same-cycle reload wins over the drain, keeping full throughput.
      if (xfer_in) begin
        obuf_valid <= 1'b1;
        obuf       <= sel_beat;
      end else if (out.rtr) begin
        obuf_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            state       <= LOCKED;
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            first_beat  <= 1'b1;
          end
        end
        LOCKED: begin
          if (xfer_in) begin
            first_beat <= 1'b0;
            if (first_beat && !sel_beat[SOW_B]) proto_err <= 1'b1;
            if (sel_beat[EOW_B]) begin
              pkt_cnt     <= pkt_cnt + 32'd1;
              state       <= IDLE;
              grant_valid <= 1'b0;
              ptr         <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pd_stream_arbiter.sv
// Directed bench for pd_stream_arbiter: one task per scenario with inline checks.
module tb_pd_stream_arbiter
  import posit_defines::*;
;
  localparam int SW = get_scale_width(32, 2, NORMAL);
  localparam int FW = get_fraction_width(32, 2, NORMAL);
  localparam int BW = SW + FW + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          out_rtr;
  logic          in_rts   [4];
  logic          in_sow   [4];
  logic          in_eow   [4];
  logic [5:0]    in_flag  [4];
  logic [SW-1:0] in_scale [4];
  logic [FW-1:0] in_frac  [4];
  logic          in_rtr   [4];
  logic [1:0]    grant_id;
  logic          grant_valid;
  logic          proto_err;
  logic [31:0]   pkt_cnt;

  pd_control_if #(.POSIT_WIDTH(32), .POSIT_ES(2), .PD_TYPE(NORMAL)) in_if [4] ();
  pd_control_if #(.POSIT_WIDTH(32), .POSIT_ES(2), .PD_TYPE(NORMAL)) out_if ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign in_if[g].rts      = in_rts[g];
    assign in_if[g].sow      = in_sow[g];
    assign in_if[g].eow      = in_eow[g];
    assign {in_if[g].nar, in_if[g].sign, in_if[g].zero,
            in_if[g].guard, in_if[g].round, in_if[g].sticky} = in_flag[g];
    assign in_if[g].scale    = in_scale[g];
    assign in_if[g].fraction = in_frac[g];
    assign in_rtr[g]         = in_if[g].rtr;
  end
  assign out_if.rtr = out_rtr;

  pd_stream_arbiter #(.POSIT_WIDTH(32), .POSIT_ES(2), .PD_TYPE(NORMAL), .N_REQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_if),
    .out         (out_if),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .proto_err   (proto_err),
    .pkt_cnt     (pkt_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rtr_viol = 0;
  int bp_viol = 0;
  int stall_seen = 0;
  logic prev_gv = 1'b0;
  logic [BW-1:0] got_q [$];
  int gnt_q [$];
  int acc_r_q [$];
  int acc_cyc_q [$];
  int out_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observes handshakes mid-cycle, where inputs and combinational rtr are settled.
  always @(negedge clk) begin
    int nrtr;
    nrtr = 0;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (in_rtr[i]) begin
          nrtr++;
          if (in_rts[i]) begin
            acc_r_q.push_back(i);
            acc_cyc_q.push_back(cyc);
          end
        end
      end
      if (nrtr > 1 || (nrtr == 1 && (!grant_valid || !in_rtr[grant_id]))) rtr_viol++;
      if (out_if.rts && !out_rtr) begin
        stall_seen++;
        if (nrtr != 0) bp_viol++;
      end
      if (out_if.rts && out_rtr) begin
        got_q.push_back({out_if.sow, out_if.eow, out_if.nar, out_if.sign, out_if.zero,
                         out_if.guard, out_if.round, out_if.sticky, out_if.scale, out_if.fraction});
        out_cyc_q.push_back(cyc);
      end
      if (grant_valid && !prev_gv) gnt_q.push_back(int'(grant_id));
    end
    prev_gv = grant_valid;
  end

  function automatic logic [BW-1:0] mk_beat(input int r, input int nb, input int tag,
                                            input int b, input bit fs, input bit le);
    logic s, e;
    s = (b == 0) && fs;
    e = (b == nb - 1) && le;
    return {s, e, 6'(tag + b), SW'(r), FW'(tag * 16 + b)};
  endfunction

  function automatic logic [BW-1:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  function automatic int gnt_at(input int i);
    return (i < gnt_q.size()) ? gnt_q[i] : -1;
  endfunction

  task automatic clear_logs();
    got_q.delete(); gnt_q.delete(); acc_r_q.delete(); acc_cyc_q.delete(); out_cyc_q.delete();
  endtask

  task automatic send_pkt(input int r, input int nb, input int tag, input bit fs, input bit le);
    bit acc;
    int waited;
    for (int b = 0; b < nb; b++) begin
      in_rts[r]   = 1'b1;
      in_sow[r]   = (b == 0) && fs;
      in_eow[r]   = (b == nb - 1) && le;
      in_flag[r]  = 6'(tag + b);
      in_scale[r] = SW'(r);
      in_frac[r]  = FW'(tag * 16 + b);
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_rtr[r];
        @(posedge clk); #1;
        waited++;
        if (!acc && waited > 200) begin
          tests++; fails++;
          $display("FAIL send_timeout: req %0d beat %0d not accepted in %0d cycles", r, b, waited);
          acc = 1'b1;
        end
      end
    end
    in_rts[r] = 1'b0;
    in_sow[r] = 1'b0;
    in_eow[r] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((out_if.rts || grant_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    tests++;
    if (out_if.rts || grant_valid) begin
      fails++;
      $display("FAIL drain_timeout: out.rts=%b grant_valid=%b after %0d cycles", out_if.rts, grant_valid, n);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_rts[i] = 1'b0; in_sow[i] = 1'b0; in_eow[i] = 1'b0;
      in_flag[i] = '0; in_scale[i] = '0; in_frac[i] = '0;
    end
    out_rtr = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if (grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tests++; if (out_if.rts !== 1'b0) begin fails++; $display("FAIL reset_out_rts: got %b want 0", out_if.rts); end
    tests++; if (out_if.fraction !== '0 || out_if.scale !== '0 || out_if.eow !== 1'b0) begin
      fails++; $display("FAIL reset_out_data: frac %h scale %h eow %b want 0", out_if.fraction, out_if.scale, out_if.eow); end
    tests++; if ({in_rtr[3], in_rtr[2], in_rtr[1], in_rtr[0]} !== 4'b0000) begin
      fails++; $display("FAIL reset_in_rtr: got %b%b%b%b want 0000", in_rtr[3], in_rtr[2], in_rtr[1], in_rtr[0]); end
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    tests++; if (pkt_cnt !== 32'd0) begin fails++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
  endtask

  task automatic test_pass_through();
    int start;
    @(posedge clk); #1;
    clear_logs();
    start = cyc;
    send_pkt(2, 3, 1, 1'b1, 1'b1);
    wait_drain();
    tests++; if (gnt_at(0) != 2 || gnt_q.size() != 1) begin fails++; $display("FAIL pass_grant: got %0d (n=%0d) want 2", gnt_at(0), gnt_q.size()); end
    tests++; if (acc_cyc_q.size() < 1 || acc_cyc_q[0] != start + 1) begin fails++; $display("FAIL pass_grant_latency: first accept cycle wrong, want %0d", start + 1); end
    tests++; if (got_q.size() != 3) begin fails++; $display("FAIL pass_beat_count: got %0d want 3", got_q.size()); end
    for (int b = 0; b < 3; b++) begin
      tests++; if (got_at(b) !== mk_beat(2, 3, 1, b, 1'b1, 1'b1)) begin
        fails++; $display("FAIL pass_beat%0d: got %h want %h", b, got_at(b), mk_beat(2, 3, 1, b, 1'b1, 1'b1)); end
      tests++; if (b >= out_cyc_q.size() || b >= acc_cyc_q.size() || out_cyc_q[b] != acc_cyc_q[b] + 1) begin
        fails++; $display("FAIL pass_latency%0d: out beat not one cycle after accept", b); end
    end
    tests++; if (pkt_cnt !== 32'd1) begin fails++; $display("FAIL pass_pkt_cnt: got %0d want 1", pkt_cnt); end
    // After in[2] finished, in[3] must outrank in[0].
    fork
      send_pkt(0, 1, 2, 1'b1, 1'b1);
      send_pkt(3, 1, 3, 1'b1, 1'b1);
    join
    wait_drain();
    tests++; if (gnt_at(1) != 3 || gnt_at(2) != 0) begin fails++; $display("FAIL pass_ptr_next: got %0d,%0d want 3,0", gnt_at(1), gnt_at(2)); end
    tests++; if (pkt_cnt !== 32'd3) begin fails++; $display("FAIL pass_pkt_cnt3: got %0d want 3", pkt_cnt); end
  endtask

  task automatic test_fairness();
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_logs();
    fork
      begin send_pkt(0, 1, 16, 1'b1, 1'b1); send_pkt(0, 1, 17, 1'b1, 1'b1); end
      begin send_pkt(1, 1, 18, 1'b1, 1'b1); send_pkt(1, 1, 19, 1'b1, 1'b1); end
      begin send_pkt(2, 1, 20, 1'b1, 1'b1); send_pkt(2, 1, 21, 1'b1, 1'b1); end
      begin send_pkt(3, 1, 22, 1'b1, 1'b1); send_pkt(3, 1, 23, 1'b1, 1'b1); end
    join
    wait_drain();
    tests++; if (gnt_q.size() != 8) begin fails++; $display("FAIL fair_grant_count: got %0d want 8", gnt_q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (gnt_at(i) != exp_g[i]) begin fails++; $display("FAIL fair_order%0d: got %0d want %0d", i, gnt_at(i), exp_g[i]); end
    end
    tests++; if (pkt_cnt !== 32'd8) begin fails++; $display("FAIL fair_pkt_cnt: got %0d want 8", pkt_cnt); end
  endtask

  task automatic test_atomicity();
    int v0;
    @(posedge clk); #1;
    clear_logs();
    v0 = rtr_viol;
    fork
      send_pkt(0, 4, 4, 1'b1, 1'b1);
      send_pkt(1, 4, 5, 1'b1, 1'b1);
    join
    wait_drain();
    tests++; if (got_q.size() != 8) begin fails++; $display("FAIL atom_beat_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got_at(i) !== mk_beat(i / 4, 4, (i < 4) ? 4 : 5, i % 4, 1'b1, 1'b1)) begin
        fails++; $display("FAIL atom_beat%0d: got %h want %h", i, got_at(i), mk_beat(i / 4, 4, (i < 4) ? 4 : 5, i % 4, 1'b1, 1'b1)); end
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (i >= acc_r_q.size() || acc_r_q[i] != 0) begin fails++; $display("FAIL atom_accept%0d: in[1] accepted during in[0] packet", i); end
    end
    tests++; if (rtr_viol != v0) begin fails++; $display("FAIL atom_rtr_owner: %0d cycles with rtr off-owner, want 0", rtr_viol - v0); end
  endtask

  task automatic test_backpressure();
    int n;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    clear_logs();
    bp_viol = 0;
    stall_seen = 0;
    fork
      send_pkt(1, 5, 6, 1'b1, 1'b1);
      begin
        n = 0;
        while (!out_if.rts && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 4; i++) begin
          out_rtr = pat[i];
          @(posedge clk); #1;
        end
        out_rtr = 1'b1;
      end
    join
    wait_drain();
    tests++; if (got_q.size() != 5) begin fails++; $display("FAIL bp_beat_count: got %0d want 5", got_q.size()); end
    for (int b = 0; b < 5; b++) begin
      tests++; if (got_at(b) !== mk_beat(1, 5, 6, b, 1'b1, 1'b1)) begin
        fails++; $display("FAIL bp_beat%0d: got %h want %h", b, got_at(b), mk_beat(1, 5, 6, b, 1'b1, 1'b1)); end
    end
    tests++; if (stall_seen != 2) begin fails++; $display("FAIL bp_stall_cycles: got %0d want 2", stall_seen); end
    tests++; if (bp_viol != 0) begin fails++; $display("FAIL bp_rtr_while_full: got %0d cycles want 0", bp_viol); end
  endtask

  task automatic test_proto_err();
    @(posedge clk); #1;
    clear_logs();
    tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL perr_before: got %b want 0", proto_err); end
    send_pkt(3, 2, 7, 1'b0, 1'b1);
    wait_drain();
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr_set: got %b want 1", proto_err); end
    tests++; if (got_at(0) !== mk_beat(3, 2, 7, 0, 1'b0, 1'b1)) begin
      fails++; $display("FAIL perr_forwarded: got %h want %h", got_at(0), mk_beat(3, 2, 7, 0, 1'b0, 1'b1)); end
    send_pkt(0, 1, 8, 1'b1, 1'b1);
    wait_drain();
    tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_reset_mid_packet();
    @(posedge clk); #1;
    clear_logs();
    send_pkt(1, 2, 9, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin fails++; $display("FAIL rmid_grant: valid %b id %0d want 0 0", grant_valid, grant_id); end
    tests++; if (out_if.rts !== 1'b0 || out_if.fraction !== '0) begin fails++; $display("FAIL rmid_out: rts %b frac %h want 0 0", out_if.rts, out_if.fraction); end
    tests++; if (proto_err !== 1'b0 || pkt_cnt !== 32'd0) begin fails++; $display("FAIL rmid_status: perr %b cnt %0d want 0 0", proto_err, pkt_cnt); end
    rst_n = 1'b1;
    send_pkt(3, 2, 10, 1'b1, 1'b1);
    wait_drain();
    tests++; if (gnt_q.size() != 2 || gnt_at(1) != 3) begin fails++; $display("FAIL rmid_regrant: got %0d want 3", gnt_at(1)); end
    tests++; if (got_q.size() != 3) begin fails++; $display("FAIL rmid_beat_count: got %0d want 3", got_q.size()); end
    tests++; if (got_at(0) !== mk_beat(1, 2, 9, 0, 1'b1, 1'b0)) begin fails++; $display("FAIL rmid_beat0: got %h want %h", got_at(0), mk_beat(1, 2, 9, 0, 1'b1, 1'b0)); end
    for (int b = 0; b < 2; b++) begin
      tests++; if (got_at(b + 1) !== mk_beat(3, 2, 10, b, 1'b1, 1'b1)) begin
        fails++; $display("FAIL rmid_fresh%0d: got %h want %h", b, got_at(b + 1), mk_beat(3, 2, 10, b, 1'b1, 1'b1)); end
    end
    tests++; if (pkt_cnt !== 32'd1) begin fails++; $display("FAIL rmid_pkt_cnt: got %0d want 1", pkt_cnt); end
    tests++; if (rtr_viol != 0) begin fails++; $display("FAIL rtr_owner_total: %0d off-owner rtr cycles want 0", rtr_viol); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fairness();
    test_atomicity();
    test_backpressure();
    test_proto_err();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pd_stream_arbiter.md
# pd_stream_arbiter

Round-robin arbiter that shares one downstream posit-decoded (pd) datapath stage, such as a single adder/multiplier core, between N_REQ upstream pd_control_if producers. Arbitration is packet-atomic. A grant is held from the first granted beat through the beat carrying eow, so framed operand streams are never interleaved. One registered output stage decouples downstream rtr from upstream rtr.

## Interface
- POSIT_WIDTH, 32, posit width passed to all pd_control_if instances
- POSIT_ES, 2, exponent size passed to all pd_control_if instances
- PD_TYPE, NORMAL, pd_type passed to all pd_control_if instances
- N_REQ, 4, number of requesters; legal range 1..16
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in  pd_control_if.slave[N_REQ]  —  requester streams (rts/rtr/sow/eow plus data)
- out  pd_control_if.master  —  merged stream to the shared stage
- grant_id  output  ID_W  index of the current owner; ID_W = max(1, $clog2(N_REQ))
- grant_valid  output  1  high while LOCKED
- proto_err  output  1  sticky; set when a granted packet's first beat lacks sow
- pkt_cnt  output  32  count of eow beats accepted from inputs; wraps modulo 2^32

## Operation
- Transfer on any channel occurs when rts && rtr are both high on the same clk edge.
- FSM states: IDLE and LOCKED.
  - IDLE: all in[i].rtr = 0. If any in[i].rts is high, pick the winner by round-robin starting at index ptr. Register grant_id = winner and go to LOCKED.
  - LOCKED: only in[grant_id].rtr may be high; all other in[i].rtr = 0.
  - in[grant_id].rtr = !obuf_valid || out.rtr.
  - On a transfer with eow = 1: ptr ← grant_id+1, wrapping to 0 at N_REQ, and the FSM returns to IDLE.
- Output buffer is one entry (obuf_valid plus all data fields, sow and eow).
  - An accepted input beat is loaded into the buffer.
  - out.rts = obuf_valid.
  - The buffer clears on an out transfer unless it is reloaded in the same cycle.
  - Load and drain in the same cycle are allowed, giving full throughput.
- Data fields (scale, fraction, NaR, sign, zero, guard, round, sticky) pass through unmodified. Widths come from get_scale_width and get_fraction_width.
- First-beat check: the first accepted beat after entering LOCKED with sow = 0 sets proto_err. The beat is still forwarded.
- pkt_cnt increments on every accepted input beat with eow = 1.
- Single-beat packets (sow = eow = 1) are legal: lock and release happen on the same beat.
- A requester that drops rts mid-packet stalls the arbiter in LOCKED. There is no timeout.

## Timing
- Reset values: state = IDLE, ptr = 0, grant_id = 0, grant_valid = 0, obuf_valid = 0, out.rts = 0, out data = 0, all in[i].rtr = 0, proto_err = 0, pkt_cnt = 0.
- Reset mid-packet discards the buffer and lock immediately. Requesters must restart at sow.
- Arbitration latency: rts seen in IDLE at cycle t means grant_valid = 1 and in[g].rtr can be high at t+1.
- Every packet costs exactly one idle bubble cycle on the input side.
- Data latency: input beat accepted at edge t appears on out at t+1, with out.rts = 1 before that next edge.
- Backpressure: if out.rtr = 0 and obuf_valid = 1, then in[g].rtr = 0 in the same cycle (combinational path out.rtr → in[g].rtr).
- The eow transfer at edge t returns the FSM to IDLE at t+1. The next grant is registered at t+2, even if the same requester is the only one asserting rts.
- out.eow leaves the buffer after the FSM has already released. The buffer drains independently of the FSM state.

## Structure
- Add to posit_defines:
  - typedef pd_arb_state_t (enum: IDLE, LOCKED)
  - function get_id_width(n) returning max(1, $clog2(n))
- One sub-module, rr_pick: combinational, parameter N. Inputs req[N] and ptr; outputs any and idx. Uses a double-width rotate with a priority encoder.
- The FSM, buffer, counters and interface muxing stay in pd_stream_arbiter.

## Test plan
- Basic pass-through: N_REQ = 4, only in[2] sends a 3-beat packet with out.rtr = 1.
  - grant_id = 2 one cycle after rts.
  - out carries beats 1..3 each one cycle after acceptance, in order.
  - pkt_cnt = 1 and ptr = 3 after completion.
- Fairness: all 4 requesters hold rts with single-beat packets, starting with ptr = 0.
  - Grant order is 0, 1, 2, 3, 0.
  - No requester gets two grants before all others have had one.
- Atomicity: in[0] and in[1] each send a 4-beat packet concurrently.
  - out shows all 4 beats of in[0] contiguous, including sow and eow, then all 4 beats of in[1].
  - in[1].rtr = 0 throughout in[0]'s packet.
- Backpressure: out.rtr toggles 1, 0, 0, 1 during a 5-beat packet.
  - No beat is lost or duplicated.
  - in[g].rtr = 0 whenever obuf_valid && !out.rtr.
- Protocol error: a granted first beat arrives with sow = 0.
  - proto_err goes to 1 and stays 1 until rst_n = 0.
  - The beat is still forwarded.
- Reset mid-packet: assert rst_n = 0 for 1 cycle after beat 2 of 4.
  - All outputs return to their reset values on the next edge.
  - A fresh packet from in[3] is then granted normally, starting from ptr = 0.
